// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier issue/collect sequencer:
// FSM state encoding, default operand width, derived cycle budgets and
// the layout of one result FIFO entry.
package booth_pkg;

  // Default operand width; the product is twice as wide.
  localparam int N_DEFAULT = 4;

  // Sequencer states. The 3-bit encoding is fixed so that debug taps and
  // waveforms stay comparable across operand widths.
  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } seq_state_t;

  // Cycles spent in WAIT without a done rising edge before the op is aborted.
  function automatic int timeout_cycles(input int n);
    return 4 * n + 8;
  endfunction

  // Post-reset cycles before operands are accepted; the multiplier has no
  // reset of its own and needs this long to flush any half-finished run.
  function automatic int settle_cycles(input int n);
    return 2 * n + 4;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Result entry layout: {err, product[2N-1:0]}, err in the MSB.
  function automatic int entry_width(input int n);
    return 2 * n + 1;
  endfunction

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/booth_res_fifo.sv
// Small registered result FIFO with a first-word-fall-through head.
// Push when full and pop when empty are ignored.
module booth_res_fifo
  import booth_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_en;
  logic             pop_en;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_en) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push_en && !pop_en) begin
        count_reg <= count_reg + 1'b1;
      end else if (!push_en && pop_en) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Issue/collect stage in front of the Booth multiplier. Turns the raw
// start/done handshake into a valid/ready operand port and a result
// stream, one multiply in flight at a time, with a timeout abort.
module booth_mul_sequencer
  import booth_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int TIMEOUT    = timeout_cycles(N),
  parameter int SETTLE     = settle_cycles(N),
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [N-1:0]   op_m,
  input  logic [N-1:0]   op_q,
  output logic           mul_start,
  output logic [N-1:0]   mul_m,
  output logic [N-1:0]   mul_q,
  input  logic [2*N-1:0] mul_product,
  input  logic           mul_done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_data,
  output logic           res_err,
  output logic           busy
);

  localparam int CNT_W = $clog2(max_int(TIMEOUT, SETTLE) + 1);
  localparam int EW    = entry_width(N);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             done_d_reg;
  logic [N-1:0]     m_reg;
  logic [N-1:0]     q_reg;

  logic             done_rise;
  logic             timeout_hit;
  logic             load_ops;
  logic             push;
  logic             push_err;
  logic             start_pulse;
  logic             accept_ok;
  logic [EW-1:0]    push_entry;

  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_dout;
  logic [FCW-1:0]   fifo_count;

  assign done_rise   = mul_done & ~done_d_reg;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign accept_ok   = (fifo_count < FCW'(FIFO_DEPTH));

  // Next-state, counter and datapath strobes; defaults hold everything.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    load_ops    = 1'b0;
    push        = 1'b0;
    push_err    = 1'b0;
    start_pulse = 1'b0;
    op_ready    = 1'b0;
    unique case (state_reg)
      ST_SETTLE: begin
        if (cnt_reg == CNT_W'(SETTLE - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_IDLE: begin
        op_ready = accept_ok;
        if (op_valid && accept_ok) begin
          load_ops   = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        start_pulse = 1'b1;
        cnt_next    = '0;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        // A done edge on the last allowed cycle still counts as success.
        if (done_rise) begin
          push       = 1'b1;
          state_next = ST_DRAIN;
        end else if (timeout_hit) begin
          push       = 1'b1;
          push_err   = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Hold off the next start until a level-style done has dropped.
        if (!mul_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_SETTLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and done-history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_SETTLE;
      cnt_reg    <= '0;
      done_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      done_d_reg <= mul_done;
    end
  end

  // Operand holding registers, stable for the whole multiply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg <= '0;
      q_reg <= '0;
    end else if (load_ops) begin
      m_reg <= op_m;
      q_reg <= op_q;
    end
  end

  // Aborted ops carry a zero product so consumers never see stale data.
  assign push_entry = push_err ? {1'b1, {(2*N){1'b0}}} : {1'b0, mul_product};

  booth_res_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push & ~fifo_full),
    .din   (push_entry),
    .full  (fifo_full),
    .pop   (res_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mul_start = start_pulse;
  assign mul_m     = m_reg;
  assign mul_q     = q_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign res_valid = ~fifo_empty;
  assign res_err   = res_valid & fifo_dout[EW-1];
  assign res_data  = res_valid ? fifo_dout[2*N-1:0] : '0;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Bench for booth_mul_sequencer: a behavioural multiplier stub with
// configurable latency, done hold time and a never-done fault mode,
// table-driven product vectors plus hand-written multi-cycle sequences.
module tb_booth_mul_sequencer;

  localparam int N       = 4;
  localparam int TIMEOUT = 24;   // 4*N+8
  localparam int SETTLE  = 12;   // 2*N+4
  localparam int LAT     = 5;    // stub multiply latency in cycles
  localparam int BOUND   = 300;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_m;
  logic [N-1:0] op_q;
  logic         mul_start;
  logic [N-1:0] mul_m;
  logic [N-1:0] mul_q;
  logic [7:0]   mul_product = 8'h00;
  logic         mul_done = 1'b0;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_data;
  logic         res_err;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  booth_mul_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_m        (op_m),
    .op_q        (op_q),
    .mul_start   (mul_start),
    .mul_m       (mul_m),
    .mul_q       (mul_q),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------- multiplier stub ----------------
  int         hold_cfg   = 1;
  bit         never_done = 1'b0;
  int         run_cnt    = 0;
  int         hold_cnt   = 0;
  logic [3:0] pm = 4'h0;
  logic [3:0] pq = 4'h0;

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    return 8'(ia * ib);
  endfunction

  always @(posedge clk) begin
    if (mul_start) begin
      run_cnt <= LAT;
      pm      <= mul_m;
      pq      <= mul_q;
    end else if (run_cnt > 0) begin
      run_cnt <= run_cnt - 1;
      if (run_cnt == 1 && !never_done) begin
        mul_done    <= 1'b1;
        hold_cnt    <= hold_cfg;
        mul_product <= smul(pm, pq);
      end
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) mul_done <= 1'b0;
    end
  end

  // ---------------- monitor (negedge sampling) ----------------
  int         cyc = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         rv_cyc = 0;
  int         done_fall_cyc = 0;
  int         idle_cyc = 0;
  int         wide_start = 0;
  int         ready_busy = 0;
  int         done_idle = 0;
  logic       start_prev = 1'b0;
  logic       rv_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic [8:0] pop_log[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mul_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      if (start_prev === 1'b1) wide_start <= wide_start + 1;
    end
    if (res_valid === 1'b1 && rv_prev !== 1'b1) rv_cyc <= cyc;
    if (mul_done === 1'b0 && done_prev === 1'b1) done_fall_cyc <= cyc;
    if (busy === 1'b0 && busy_prev === 1'b1) idle_cyc <= cyc;
    if (op_ready === 1'b1 && busy === 1'b1) ready_busy <= ready_busy + 1;
    if (mul_done === 1'b1 && busy === 1'b0) done_idle <= done_idle + 1;
    if (res_valid === 1'b1 && res_ready === 1'b1) pop_log.push_back({res_err, res_data});
    start_prev <= mul_start;
    rv_prev    <= res_valid;
    done_prev  <= mul_done;
    busy_prev  <= busy;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and hold it until the sequencer takes it.
  task automatic do_op(input logic [3:0] m, input logic [3:0] q, input string tag);
    bit ok;
    ok = 1'b0;
    op_m = m;
    op_q = q;
    op_valid = 1'b1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (op_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    op_valid = 1'b0;
    check({tag, " accepted"}, 32'(ok), 32'd1);
  endtask

  // Pop exactly one result (waits for the head to become valid).
  task automatic pop_one(input string tag);
    bit ok;
    ok = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    res_ready = 1'b0;
    check({tag, " result arrived"}, 32'(ok), 32'd1);
  endtask

  // Count negedges after reset release until op_ready first rises.
  task automatic settle_len(input string tag);
    int k;
    k = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      k++;
      if (op_ready === 1'b1) break;
    end
    step();
    // The first sampled cycle is the one loaded by the reset edge itself.
    check({tag, " op_ready rise cycle"}, 32'(k), 32'(SETTLE + 1));
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] prod;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sc;

    vecs[0] = '{m: 4'h7, q: 4'h7, prod: 8'h31, err: 1'b0};  //  7 *  7 =  49
    vecs[1] = '{m: 4'h8, q: 4'h8, prod: 8'h40, err: 1'b0};  // -8 * -8 =  64
    vecs[2] = '{m: 4'h0, q: 4'hF, prod: 8'h00, err: 1'b0};  //  0 * -1 =   0
    vecs[3] = '{m: 4'hF, q: 4'hF, prod: 8'h01, err: 1'b0};  // -1 * -1 =   1
    vecs[4] = '{m: 4'h7, q: 4'h8, prod: 8'hC8, err: 1'b0};  //  7 * -8 = -56
    vecs[5] = '{m: 4'h3, q: 4'hE, prod: 8'hFA, err: 1'b0};  //  3 * -2 =  -6
    vecs[6] = '{m: 4'h8, q: 4'h1, prod: 8'hF8, err: 1'b0};  // -8 *  1 =  -8
    vecs[7] = '{m: 4'h5, q: 4'h5, prod: 8'h19, err: 1'b0};  //  5 *  5 =  25

    rst_n = 1'b0;
    op_valid = 1'b0;
    op_m = '0;
    op_q = '0;
    res_ready = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    check("reset busy", 32'(busy), 32'd1);
    check("reset op_ready", 32'(op_ready), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", 32'(res_data), 32'h0);
    check("reset res_err", 32'(res_err), 32'd0);
    check("reset mul_start", 32'(mul_start), 32'd0);
    check("reset mul_m", 32'(mul_m), 32'h0);
    check("reset mul_q", 32'(mul_q), 32'h0);
    rst_n = 1'b1;
    settle_len("t1 settle");

    // ---- test 1: -3 * 5 ----
    sc = start_cnt;
    base = pop_log.size();
    do_op(4'hD, 4'h5, "t1");
    pop_one("t1");
    repeat (3) step();
    check("t1 start pulses", 32'(start_cnt - sc), 32'd1);
    check("t1 start-to-valid cycles", 32'(rv_cyc - start_cyc), 32'(LAT + 2));
    check("t1 pops", 32'(pop_log.size() - base), 32'd1);
    if (pop_log.size() > base) check("t1 entry", 32'(pop_log[base]), 32'h0F1);

    // ---- test 2: table vectors streamed with res_ready=1 ----
    base = pop_log.size();
    res_ready = 1'b1;
    foreach (vecs[i]) do_op(vecs[i].m, vecs[i].q, $sformatf("t2 vec%0d", i));
    for (int i = 0; i < BOUND && pop_log.size() < base + 8; i++) step();
    res_ready = 1'b0;
    check("t2 pop count", 32'(pop_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (pop_log.size() > base + i)
        check($sformatf("t2 vec%0d m=%0h q=%0h", i, vecs[i].m, vecs[i].q),
              32'(pop_log[base + i]), 32'({vecs[i].err, vecs[i].prod}));
    end

    // ---- test 3: back-pressure, FIFO full stalls the third op ----
    base = pop_log.size();
    do_op(4'h3, 4'hE, "t3a");
    do_op(4'hF, 4'hF, "t3b");
    repeat (LAT + 6) step();
    check("t3 full res_valid", 32'(res_valid), 32'd1);
    check("t3 full head data", 32'(res_data), 32'hFA);
    check("t3 full busy", 32'(busy), 32'd0);
    check("t3 full op_ready", 32'(op_ready), 32'd0);
    sc = start_cnt;
    fork
      do_op(4'h7, 4'h8, "t3c");
      begin
        repeat (10) step();
        check("t3 no launch while full", 32'(start_cnt - sc), 32'd0);
        check("t3 op_ready held low", 32'(op_ready), 32'd0);
        pop_one("t3 pop1");
        pop_one("t3 pop2");
      end
    join
    pop_one("t3 pop3");
    check("t3 third op launched", 32'(start_cnt - sc), 32'd1);
    check("t3 pop count", 32'(pop_log.size() - base), 32'd3);
    if (pop_log.size() >= base + 3) begin
      check("t3 order 0", 32'(pop_log[base]), 32'h0FA);
      check("t3 order 1", 32'(pop_log[base + 1]), 32'h001);
      check("t3 order 2", 32'(pop_log[base + 2]), 32'h0C8);
    end

    // ---- test 4: stub never answers -> timeout abort ----
    never_done = 1'b1;
    base = pop_log.size();
    do_op(4'h1, 4'h1, "t4");
    for (int i = 0; i < BOUND && res_valid !== 1'b1; i++) step();
    step();
    check("t4 res_err", 32'(res_err), 32'd1);
    check("t4 res_data", 32'(res_data), 32'h0);
    // Abort is decided on the TIMEOUT-th WAIT cycle; the entry shows one later.
    check("t4 start-to-valid cycles", 32'(rv_cyc - start_cyc), 32'(TIMEOUT + 1));
    pop_one("t4");
    never_done = 1'b0;
    do_op(4'h3, 4'hE, "t4 recover");
    pop_one("t4 recover");
    check("t4 pop count", 32'(pop_log.size() - base), 32'd2);
    if (pop_log.size() >= base + 2) begin
      check("t4 abort entry", 32'(pop_log[base]), 32'h100);
      check("t4 recover entry", 32'(pop_log[base + 1]), 32'h0FA);
    end

    // ---- test 5: done held high for 5 cycles ----
    hold_cfg = 5;
    base = pop_log.size();
    res_ready = 1'b1;
    do_op(4'h3, 4'h3, "t5");
    repeat (LAT + 12) step();
    res_ready = 1'b0;
    hold_cfg = 1;
    check("t5 single push", 32'(pop_log.size() - base), 32'd1);
    if (pop_log.size() > base) check("t5 entry", 32'(pop_log[base]), 32'h009);
    check("t5 idle one cycle after done falls", 32'(idle_cyc - done_fall_cyc), 32'd1);

    // ---- test 6: reset pulse during WAIT ----
    base = pop_log.size();
    do_op(4'h1, 4'h2, "t6 abandoned");
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6 res_valid after reset", 32'(res_valid), 32'd0);
    check("t6 busy after reset", 32'(busy), 32'd1);
    settle_len("t6 settle");
    check("t6 no stray entry", 32'(res_valid), 32'd0);
    do_op(4'h2, 4'h3, "t6");
    pop_one("t6");
    check("t6 pop count", 32'(pop_log.size() - base), 32'd1);
    if (pop_log.size() > base) check("t6 entry", 32'(pop_log[base]), 32'h006);

    // ---- run-wide protocol invariants ----
    check("mul_start wider than 1 cycle", 32'(wide_start), 32'd0);
    check("op_ready while busy", 32'(ready_busy), 32'd0);
    check("mul_done high while idle", 32'(done_idle), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
